// File: rtl/core_l1d_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_l1d_ctrl
// Description : Data-cache transaction sequencer for the memory stage.
//               Registers a load/store from the stage, issues it on the L1D
//               request bus with a val/ack handshake, waits for load data,
//               and stalls the pipeline until the access completes. Kills
//               that arrive mid-transaction are absorbed by draining the
//               orphaned bus traffic.
//
// Ports       : clk, rst                 - core clock, async active-high reset
//               mem_req_*_in, mem_kill_in - memory-stage request and kill
//               l1d_req_*                 - L1D request bus (val/ack)
//               l1d_rsp_val/data          - L1D load response
//               ctrl_stall_out            - pipeline hold (stage enable = !stall)
//               ctrl_rdata_out/val_out    - captured load data + 1-cycle valid
//
// Revision    : 1.0 - initial release
// ============================================================================
module core_l1d_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_val_in,
    input  logic [2:0]  mem_req_cop_in,
    input  logic [2:0]  mem_req_size_in,
    input  logic [31:0] mem_req_addr_in,
    input  logic [31:0] mem_req_wdata_in,
    input  logic        mem_kill_in,
    output logic        l1d_req_val,
    output logic [2:0]  l1d_req_cop,
    output logic [2:0]  l1d_req_size,
    output logic [31:0] l1d_req_addr,
    output logic [31:0] l1d_req_wdata,
    input  logic        l1d_req_ack,
    input  logic        l1d_rsp_val,
    input  logic [31:0] l1d_rsp_data,
    output logic        ctrl_stall_out,
    output logic [31:0] ctrl_rdata_out,
    output logic        ctrl_rdata_val_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_RSP   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_kill_pend;

    logic       w_killed;     // current access has been killed (now or earlier)
    logic       w_is_store;   // latched operation is a store
    logic       w_accept;     // latch a new request from the stage
    logic       w_capture;    // capture load data into ctrl_rdata_out

    assign w_killed   = r_kill_pend | mem_kill_in;
    assign w_is_store = l1d_req_cop[0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_req_val_in && !mem_kill_in) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // Response cannot arrive before the cycle after ack, so
                // l1d_rsp_val is not looked at here.
                if (l1d_req_ack) begin
                    if (w_killed) begin
                        // A killed store still completes in memory; nothing
                        // comes back, so return straight to IDLE.
                        w_state_nxt = w_is_store ? S_IDLE : S_DRAIN;
                    end else begin
                        w_state_nxt = w_is_store ? S_DONE : S_RSP;
                    end
                end
            end
            S_RSP: begin
                if (l1d_rsp_val) begin
                    w_state_nxt = w_killed ? S_IDLE : S_DONE;
                end else if (w_killed) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (l1d_rsp_val) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept           = (r_state == S_IDLE) && mem_req_val_in && !mem_kill_in;
        w_capture          = (r_state == S_RSP) && l1d_rsp_val && !w_killed;
        ctrl_rdata_val_out = (r_state == S_DONE) && !w_is_store;
        // The stage only advances in DONE; a request shadowed behind a
        // killed access stays stalled until this block is back in IDLE.
        ctrl_stall_out     = !rst && mem_req_val_in && !mem_kill_in &&
                             (r_state != S_DONE);
    end

    // ------------------------------------------------------------------
    // Request registers, kill tracking and load-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kill_pend    <= 1'b0;
            l1d_req_val    <= 1'b0;
            l1d_req_cop    <= 3'd0;
            l1d_req_size   <= 3'd0;
            l1d_req_addr   <= 32'd0;
            l1d_req_wdata  <= 32'd0;
            ctrl_rdata_out <= 32'd0;
        end else begin
            if (w_state_nxt == S_IDLE) begin
                r_kill_pend <= 1'b0;
            end else if (mem_kill_in && ((r_state == S_REQ) || (r_state == S_RSP))) begin
                r_kill_pend <= 1'b1;
            end

            // Fields are only written on accept, so they stay stable for
            // the whole time the request is on the bus.
            if (w_accept) begin
                l1d_req_val   <= 1'b1;
                l1d_req_cop   <= mem_req_cop_in;
                l1d_req_size  <= mem_req_size_in;
                l1d_req_addr  <= mem_req_addr_in;
                l1d_req_wdata <= mem_req_wdata_in;
            end else if ((r_state == S_REQ) && l1d_req_ack) begin
                l1d_req_val   <= 1'b0;
            end

            if (w_capture) begin
                ctrl_rdata_out <= l1d_rsp_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/core_l1d_ctrl.md
# core_l1d_ctrl

Sequencer for data-cache transactions issued by the memory stage. It registers a load/store presented by the stage and drives the L1D request bus with a val/ack handshake. For loads it waits for the response, then returns read data. It stalls the pipeline (deasserts the stage enable) until the access completes, and absorbs kills that arrive mid-transaction by draining the orphaned bus traffic.

## Interface
- No parameters; all data and address paths are 32 bits.
- clk  in  1  core clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_req_val_in  in  1  memory stage holds a load/store
- mem_req_cop_in  in  3  operation code; bit0 = 1 store, 0 load; bits[2:1] passed through
- mem_req_size_in  in  3  access size code, passed through
- mem_req_addr_in  in  32  byte address
- mem_req_wdata_in  in  32  store data
- mem_kill_in  in  1  instruction in memory stage is killed
- l1d_req_val  out  1  request valid
- l1d_req_cop / l1d_req_size  out  3 / 3  latched cop / size
- l1d_req_addr / l1d_req_wdata  out  32 / 32  latched address / data
- l1d_req_ack  in  1  L1D accepts request this cycle
- l1d_rsp_val  in  1  load response valid
- l1d_rsp_data  in  32  load data
- ctrl_stall_out  out  1  hold the pipeline; memory-stage enable = !ctrl_stall_out
- ctrl_rdata_out  out  32  captured load data
- ctrl_rdata_val_out  out  1  one-cycle pulse: ctrl_rdata_out valid for writeback

## Operation
- States:
  - IDLE
  - REQ: request on bus
  - RSP: load awaiting data
  - DONE: completion cycle
  - DRAIN: killed load awaiting data to discard
- kill_pend: internal flag. Set by mem_kill_in in REQ/RSP. Cleared on entry to IDLE.
- IDLE:
  - mem_req_val_in & !mem_kill_in → latch cop/size/addr/wdata into the l1d_req_* registers, set l1d_req_val, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - l1d_req_val held at 1 and all l1d_req_* fields stable until ack. A request is never withdrawn.
  - On ack, clear l1d_req_val. Next state:
    - killed (kill_pend | mem_kill_in) store → IDLE
    - killed load → DRAIN
    - store → DONE
    - load → RSP
  - l1d_rsp_val is ignored in REQ. L1D guarantees the response comes no earlier than the cycle after ack.
- RSP:
  - rsp_val & !killed → capture l1d_rsp_data into ctrl_rdata_out, go to DONE.
  - rsp_val & killed → IDLE, data discarded.
  - Kill without rsp_val → DRAIN.
- DRAIN: on rsp_val → IDLE, data discarded.
- DONE:
  - ctrl_rdata_val_out = 1 for loads, 0 for stores.
  - Go to IDLE unconditionally. The pipeline advances at the end of this cycle, so the same request is never reissued.
- ctrl_stall_out = mem_req_val_in & !mem_kill_in & (state != DONE). It is combinational.
  - A new request arriving during REQ/RSP/DRAIN of a killed access is held until the controller returns to IDLE.
- A store killed after issue still completes in memory. The hazard unit must not kill a memory-stage store once issued. This is out of scope for this block.

## Timing
- Reset values:
  - state = IDLE; kill_pend = 0
  - l1d_req_val = 0; l1d_req_cop/size/addr/wdata = 0
  - ctrl_rdata_out = 0; ctrl_rdata_val_out = 0
  - ctrl_stall_out forced to 0 while rst is high
- Reset mid-transaction aborts immediately, with no drain. The L1D is reset by the same rst.
- Store with ack in the first REQ cycle: 3 cycles in stage (IDLE, REQ, DONE). Stall high for 2 cycles.
- Load with ack in the first REQ cycle and rsp_val in the next cycle: 4 cycles (IDLE, REQ, RSP, DONE). ctrl_rdata_val_out pulses in cycle 4.
- Each cycle of ack or rsp_val delay adds exactly one stall cycle.
- ctrl_rdata_val_out is high only in DONE after a load. ctrl_rdata_out holds its value until the next load capture.
- mem_kill_in in the same cycle as ack/rsp_val counts as a kill.

## Test plan
- Store, addr 0x100, wdata 0xDEADBEEF, ack in first REQ cycle → l1d_req_val high exactly 1 cycle with those fields; stall 1,1,0; no rdata pulse.
- Load, addr 0x200, ack delayed 3 cycles, rsp_val 2 cycles after ack with 0x12345678 → l1d_req fields stable all 4 REQ cycles; ctrl_rdata_out = 0x12345678 with a 1-cycle val pulse in DONE; stall drops only in DONE.
- Load killed during REQ (before ack), then a new load presented → request held until ack; DRAIN swallows the response (no rdata pulse); new load stalled, then issued from IDLE.
- Kill in the same cycle as rsp_val → IDLE next; ctrl_rdata_out unchanged; no rdata pulse.
- Back-to-back: store then load, both ack immediately, rsp next cycle → no duplicate issue; second request issued the cycle after DONE.
- rst asserted in RSP → all outputs zero asynchronously; later rsp_val in IDLE ignored.
